// File: rtl/truth_table_checker_pkg.sv
// ----------------------------------------------------------------------------
// truth_table_checker_pkg
// Shared definitions for the truth-table checker slice: the FSM state
// encoding, the default sweep width and settle time, and a small helper
// that tells whether a state counts as "sweep in progress".
// ----------------------------------------------------------------------------
package truth_table_checker_pkg;

    localparam int N_IN_DEFAULT   = 6;
    localparam int SETTLE_DEFAULT = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } tt_state_e;

    function automatic logic is_busy_state(input tt_state_e s);
        return (s == WAIT) || (s == CHECK);
    endfunction

endpackage

// File: rtl/truth_table_checker_if.sv
// ----------------------------------------------------------------------------
// truth_table_checker_if
// Bundles the checker's control, expected-table, DUT-stimulus and result
// signals.
//   master : environment side (drives start/abort/tt/dut_out, reads results)
//   slave  : checker side (reads start/abort/tt/dut_out, drives stim/results)
// ----------------------------------------------------------------------------
interface truth_table_checker_if
    import truth_table_checker_pkg::*;
    #(parameter int N_IN = N_IN_DEFAULT);

    logic                 start;
    logic                 abort;
    logic [2**N_IN-1:0]   tt;
    logic [N_IN-1:0]      stim;
    logic                 dut_out;
    logic                 busy;
    logic                 done;
    logic                 pass;
    logic [N_IN:0]        err_count;
    logic [N_IN-1:0]      first_fail;
    logic                 first_fail_vld;

    modport master (
        output start, abort, tt, dut_out,
        input  stim, busy, done, pass, err_count, first_fail, first_fail_vld
    );

    modport slave (
        input  start, abort, tt, dut_out,
        output stim, busy, done, pass, err_count, first_fail, first_fail_vld
    );

endinterface

// File: rtl/truth_table_checker_settle_timer.sv
// ----------------------------------------------------------------------------
// tt_settle_timer
// Counts the cycles a stimulus pattern has been held.
//   clk, rst_n : clock and asynchronous active-low reset
//   load       : restart the count at 0 (a new pattern is being applied)
//   expire     : high during the last settle cycle of the current pattern
// ----------------------------------------------------------------------------
module tt_settle_timer
    import truth_table_checker_pkg::*;
    #(parameter int SETTLE = SETTLE_DEFAULT)
    (
        input  logic clk,
        input  logic rst_n,
        input  logic load,
        output logic expire
    );

    localparam logic [7:0] LAST = 8'(SETTLE - 1);

    logic [7:0] cnt;

    // The count saturates at LAST so it can never wrap while the FSM sits in
    // CHECK or IDLE; every entry into WAIT reloads it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'd0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 8'd1;
        end
    end

    assign expire = (cnt == LAST);

endmodule

// File: rtl/truth_table_checker.sv
// ----------------------------------------------------------------------------
// truth_table_checker
// Sweeps all 2**N_IN input patterns into an external DUT, holds each for
// SETTLE cycles, then compares the DUT response against the expected truth
// table and accumulates a mismatch count and the lowest failing pattern.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave modport (start/abort/tt/dut_out in;
//                stim/busy/done/pass/err_count/first_fail/first_fail_vld out)
// ----------------------------------------------------------------------------
module truth_table_checker
    import truth_table_checker_pkg::*;
    #(
        parameter int N_IN   = N_IN_DEFAULT,
        parameter int SETTLE = SETTLE_DEFAULT
    )
    (
        input  logic                   clk,
        input  logic                   rst_n,
        truth_table_checker_if.slave   bus
    );

    localparam logic [N_IN-1:0] STIM_LAST = '1;
    localparam logic [N_IN-1:0] STIM_ONE  = N_IN'(1);
    localparam logic [N_IN:0]   ERR_ONE   = (N_IN + 1)'(1);

    tt_state_e       state;
    tt_state_e       next_state;

    logic [N_IN-1:0] stim_q,  stim_d;
    logic [N_IN:0]   err_q,   err_d;
    logic [N_IN-1:0] ff_q,    ff_d;
    logic            ffv_q,   ffv_d;
    logic            busy_q,  busy_d;
    logic            done_q,  done_d;
    logic            pass_q,  pass_d;

    logic            start_ok;
    logic            mismatch;
    logic            load;
    logic            expire;

    // start is only honoured between sweeps, and abort always overrides it.
    assign start_ok = bus.start && !bus.abort && ((state == IDLE) || (state == DONE));

    // tt is looked at only while in CHECK.
    assign mismatch = (state == CHECK) && (bus.dut_out != bus.tt[stim_q]);

    // Reload the settle count whenever a pattern starts being applied.
    assign load = start_ok ||
                  ((state == CHECK) && !bus.abort && (stim_q != STIM_LAST));

    tt_settle_timer #(.SETTLE(SETTLE)) u_settle (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (load),
        .expire (expire)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state = state;
        if (bus.abort) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE, DONE: if (bus.start) next_state = WAIT;
                WAIT:       if (expire)    next_state = CHECK;
                CHECK:      next_state = (stim_q == STIM_LAST) ? DONE : WAIT;
                default:    next_state = IDLE;
            endcase
        end
    end

    // Output logic: next values of the registered outputs. Abort freezes
    // stim and results; only busy/done/pass fall because the state goes IDLE.
    always_comb begin
        stim_d = stim_q;
        err_d  = err_q;
        ff_d   = ff_q;
        ffv_d  = ffv_q;
        busy_d = is_busy_state(next_state);
        done_d = (next_state == DONE);
        if (!bus.abort) begin
            if (start_ok) begin
                stim_d = '0;
                err_d  = '0;
                ff_d   = '0;
                ffv_d  = 1'b0;
            end else if (state == CHECK) begin
                if (mismatch) begin
                    err_d = err_q + ERR_ONE;
                    if (!ffv_q) begin
                        ff_d  = stim_q;
                        ffv_d = 1'b1;
                    end
                end
                if (stim_q != STIM_LAST) begin
                    stim_d = stim_q + STIM_ONE;
                end
            end
        end
        pass_d = done_d && (err_d == '0);
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stim_q <= '0;
            err_q  <= '0;
            ff_q   <= '0;
            ffv_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            pass_q <= 1'b0;
        end else begin
            stim_q <= stim_d;
            err_q  <= err_d;
            ff_q   <= ff_d;
            ffv_q  <= ffv_d;
            busy_q <= busy_d;
            done_q <= done_d;
            pass_q <= pass_d;
        end
    end

    assign bus.stim           = stim_q;
    assign bus.err_count      = err_q;
    assign bus.first_fail     = ff_q;
    assign bus.first_fail_vld = ffv_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.pass           = pass_q;

endmodule
